// File: rtl/register_unit_n_if.sv
// Bus bundle for the X:A:B shift-register unit: control/data inputs and
// register/handshake outputs, with master (controller) and slave (unit) views.
interface register_unit_n_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(2*WIDTH+2);

  logic             Ld_A;
  logic             Ld_B;
  logic             Clear_XA;
  logic [WIDTH-1:0] D_A;
  logic [WIDTH-1:0] D_B;
  logic             Shift_En;
  logic             Dir;
  logic             Arith;
  logic             X_In;
  logic             Burst_Start;
  logic [CNT_W-1:0] Burst_Len;
  logic             X;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             A_out;
  logic             B_out;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Shift_Count;

  modport master (
    output Ld_A, Ld_B, Clear_XA, D_A, D_B, Shift_En, Dir, Arith, X_In,
           Burst_Start, Burst_Len,
    input  X, A, B, A_out, B_out, Busy, Done, Shift_Count
  );

  modport slave (
    input  Ld_A, Ld_B, Clear_XA, D_A, D_B, Shift_En, Dir, Arith, X_In,
           Burst_Start, Burst_Len,
    output X, A, B, A_out, B_out, Busy, Done, Shift_Count
  );
endinterface

// File: rtl/register_unit_n.sv
// X:A:B shift-register unit: parallel load/clear, single-step and self-timed
// burst shifts over one (2*WIDTH+1)-bit path, with a Busy/Done handshake.
//
// state   | meaning
// S_IDLE  | accepts burst start, clear/loads, or a single shift step
// S_SHIFT | burst running, one shift per edge, counter counts down
// S_DONE  | one-cycle Done pulse, all requests ignored
module register_unit_n #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  register_unit_n_if.slave   bus
);
  localparam int CNT_W = $clog2(2*WIDTH+2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2*WIDTH:0] path;
  logic [2*WIDTH:0] path_shifted;

  assign path = {x_q, a_q, b_q};

  always_comb begin
    if (bus.Dir) begin
      path_shifted = {path[2*WIDTH-1:0], bus.X_In};
    end else begin
      path_shifted = {(bus.Arith ? x_q : bus.X_In), path[2*WIDTH:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Burst_Start) begin
          if (bus.Burst_Len != '0) begin
            cnt_d   = bus.Burst_Len;
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end else if (bus.Clear_XA || bus.Ld_A || bus.Ld_B) begin
          // any clear/load suppresses the single-step shift this cycle
          if (bus.Clear_XA) begin
            x_d = 1'b0;
            a_d = '0;
          end else if (bus.Ld_A) begin
            a_d = bus.D_A;
          end
          if (bus.Ld_B) begin
            b_d = bus.D_B;
          end
        end else if (bus.Shift_En) begin
          {x_d, a_d, b_d} = path_shifted;
        end
      end
      S_SHIFT: begin
        {x_d, a_d, b_d} = path_shifted;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.X           = x_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.A_out       = a_q[0];
  assign bus.B_out       = b_q[0];
  assign bus.Busy        = (state_q == S_SHIFT);
  assign bus.Done        = (state_q == S_DONE);
  assign bus.Shift_Count = cnt_q;
endmodule

// File: tb/tb_register_unit_n.sv
// Self-checking bench for register_unit_n: a path/remaining-count model checked
// every cycle, plus hand-computed literal expectations for the directed vectors.
module tb_register_unit_n;
  localparam int W     = 8;
  localparam int CNT_W = $clog2(2*W+2);

  logic Clk = 1'b0;
  logic Reset;

  register_unit_n_if #(.WIDTH(W)) bus ();

  register_unit_n #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // model: the whole path as one vector, bursts as a remaining-shift count
  logic [2*W:0] m_vec  = '0;
  int           m_rem  = 0;
  bit           m_done = 1'b0;

  function automatic logic [2*W:0] do_shift(input logic [2*W:0] v);
    if (bus.Dir) return {v[2*W-1:0], bus.X_In};
    else         return {(bus.Arith ? v[2*W] : bus.X_In), v[2*W:1]};
  endfunction

  always @(posedge Clk) begin
    logic [2*W:0] v;
    int           r;
    bit           d;
    v = m_vec;
    r = m_rem;
    d = 1'b0;
    if (!Reset) begin
      v = '0;
      r = 0;
    end else if (m_done) begin
      r = 0;
    end else if (m_rem > 0) begin
      v = do_shift(v);
      r = r - 1;
      d = (r == 0);
    end else if (bus.Burst_Start) begin
      if (bus.Burst_Len == '0) d = 1'b1;
      else                     r = int'(bus.Burst_Len);
    end else if (bus.Clear_XA || bus.Ld_A || bus.Ld_B) begin
      if (bus.Clear_XA)  v[2*W:W]   = '0;
      else if (bus.Ld_A) v[2*W-1:W] = bus.D_A;
      if (bus.Ld_B)      v[W-1:0]   = bus.D_B;
    end else if (bus.Shift_En) begin
      v = do_shift(v);
    end
    m_vec  <= v;
    m_rem  <= r;
    m_done <= d;
  end

  // literal expectations posted by the stimulus for the next check point
  bit          cmp_en   = 1'b0;
  bit          lit_regs = 1'b0;
  bit          lit_hs   = 1'b0;
  logic        lit_x;
  logic [W-1:0] lit_a, lit_b;
  logic        lit_busy, lit_done;
  int          lit_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("X",           32'(bus.X),           32'(m_vec[2*W]));
      chk("A",           32'(bus.A),           32'(m_vec[2*W-1:W]));
      chk("B",           32'(bus.B),           32'(m_vec[W-1:0]));
      chk("A_out",       32'(bus.A_out),       32'(m_vec[W]));
      chk("B_out",       32'(bus.B_out),       32'(m_vec[0]));
      chk("Busy",        32'(bus.Busy),        32'(m_rem > 0));
      chk("Done",        32'(bus.Done),        32'(m_done));
      chk("Shift_Count", 32'(bus.Shift_Count), 32'(m_rem));
    end
    if (lit_regs) begin
      chk("lit_X",     32'(bus.X),     32'(lit_x));
      chk("lit_A",     32'(bus.A),     32'(lit_a));
      chk("lit_B",     32'(bus.B),     32'(lit_b));
      chk("lit_A_out", 32'(bus.A_out), 32'(lit_a[0]));
      chk("lit_B_out", 32'(bus.B_out), 32'(lit_b[0]));
    end
    if (lit_hs) begin
      chk("lit_Busy",  32'(bus.Busy),        32'(lit_busy));
      chk("lit_Done",  32'(bus.Done),        32'(lit_done));
      chk("lit_Count", 32'(bus.Shift_Count), 32'(lit_cnt));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    lit_regs = 1'b0;
    lit_hs   = 1'b0;
  endtask

  task automatic exp_regs(input logic x, input logic [W-1:0] a, input logic [W-1:0] b);
    lit_x = x; lit_a = a; lit_b = b; lit_regs = 1'b1;
  endtask

  task automatic exp_hs(input logic busy, input logic done, input int cnt);
    lit_busy = busy; lit_done = done; lit_cnt = cnt; lit_hs = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.Ld_A = 0; bus.Ld_B = 0; bus.Clear_XA = 0; bus.Shift_En = 0;
    bus.Burst_Start = 0;
  endtask

  initial begin
    Reset = 1'b0;
    bus.D_A = '0; bus.D_B = '0; bus.Dir = 0; bus.Arith = 0; bus.X_In = 0;
    bus.Burst_Len = '0;
    idle_inputs();
    tick();
    tick();
    cmp_en = 1'b1;
    exp_regs(0, 8'h00, 8'h00); exp_hs(0, 0, 0);
    Reset = 1'b1;
    tick();

    // parallel load
    bus.Ld_A = 1; bus.D_A = 8'hA5; bus.Ld_B = 1; bus.D_B = 8'h3C;
    tick(); idle_inputs();
    exp_regs(0, 8'hA5, 8'h3C);

    // single logical right shift
    bus.Shift_En = 1; bus.Dir = 0; bus.Arith = 0; bus.X_In = 1;
    tick(); idle_inputs();
    exp_regs(1, 8'h52, 8'h9E);

    // arithmetic burst of 8, with ignored requests mid-burst
    bus.Burst_Start = 1; bus.Burst_Len = CNT_W'(8); bus.Arith = 1; bus.Dir = 0; bus.X_In = 0;
    tick(); idle_inputs();
    exp_regs(1, 8'h52, 8'h9E); exp_hs(1, 0, 8);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        bus.Ld_A = 1; bus.D_A = 8'h11; bus.Shift_En = 1; bus.Burst_Start = 1;
      end
      tick(); idle_inputs();
      exp_hs(k < 8, k == 8, 8 - k);
    end
    exp_regs(1, 8'hFF, 8'h52);
    tick();
    exp_hs(0, 0, 0);

    // clear beats Ld_A for A; B loads alongside
    bus.Arith = 0;
    bus.Clear_XA = 1; bus.Ld_A = 1; bus.D_A = 8'h77; bus.Ld_B = 1; bus.D_B = 8'h01;
    tick(); idle_inputs();
    exp_regs(0, 8'h00, 8'h01);
    bus.Ld_A = 1; bus.D_A = 8'h80;
    tick(); idle_inputs();
    exp_regs(0, 8'h80, 8'h01);

    // single left shift
    bus.Shift_En = 1; bus.Dir = 1; bus.X_In = 0;
    tick(); idle_inputs();
    exp_regs(1, 8'h00, 8'h02);

    // zero-length burst
    bus.Burst_Start = 1; bus.Burst_Len = '0;
    tick(); idle_inputs();
    exp_regs(1, 8'h00, 8'h02); exp_hs(0, 1, 0);
    tick();
    exp_regs(1, 8'h00, 8'h02); exp_hs(0, 0, 0);

    // load with shift request: load wins, no shift
    bus.Ld_A = 1; bus.D_A = 8'h33; bus.Shift_En = 1; bus.Dir = 0;
    tick(); idle_inputs();
    exp_regs(1, 8'h33, 8'h02);

    // left shift with X_In=1
    bus.Shift_En = 1; bus.Dir = 1; bus.X_In = 1;
    tick(); idle_inputs();
    exp_regs(0, 8'h66, 8'h05);

    // reset after 3 burst shifts
    bus.Burst_Start = 1; bus.Burst_Len = CNT_W'(8); bus.Dir = 0; bus.Arith = 0; bus.X_In = 1;
    tick(); idle_inputs();
    for (int k = 1; k <= 3; k++) tick();
    exp_hs(1, 0, 5);
    Reset = 1'b0;
    tick();
    exp_regs(0, 8'h00, 8'h00); exp_hs(0, 0, 0);
    Reset = 1'b1;
    tick();
    exp_regs(0, 8'h00, 8'h00); exp_hs(0, 0, 0);
    tick();
    exp_hs(0, 0, 0);

    // over-range burst of 31 logical right shifts flushes the path
    bus.Ld_A = 1; bus.D_A = 8'hFF; bus.Ld_B = 1; bus.D_B = 8'hC3;
    tick(); idle_inputs();
    bus.Burst_Start = 1; bus.Burst_Len = CNT_W'(31); bus.Dir = 0; bus.Arith = 0; bus.X_In = 0;
    tick(); idle_inputs();
    exp_hs(1, 0, 31);
    for (int k = 1; k <= 31; k++) tick();
    exp_regs(0, 8'h00, 8'h00); exp_hs(0, 1, 0);
    tick();
    exp_hs(0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/register_unit_n.md
# register_unit_n

Parametrised X:A:B shift-register unit for the multiplier datapath. It holds a sign/extension bit X plus two WIDTH-bit registers A and B, chained as one (2*WIDTH+1)-bit shift path. It supports parallel load, clear of X:A, single-step shifts and self-timed burst shifts. Shifts can be logical or arithmetic, left or right. A burst is started by the control FSM and reports completion with a Busy/Done handshake.

## Interface
Parameters:
- WIDTH, 8, width of A and B (≥2)
- CNT_W, $clog2(2*WIDTH+2), width of burst length/counter (derived, not overridden)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Ld_A  in  1  load D_A into A
- Ld_B  in  1  load D_B into B
- Clear_XA  in  1  zero X and A (B untouched)
- D_A  in  WIDTH  parallel data for A
- D_B  in  WIDTH  parallel data for B
- Shift_En  in  1  perform one shift step
- Dir  in  1  0 = right, 1 = left
- Arith  in  1  right shifts only: 1 = X refills from itself, 0 = X refills from X_In
- X_In  in  1  serial input (X on logical right, B[0] on left)
- Burst_Start  in  1  start a burst of Burst_Len shifts
- Burst_Len  in  CNT_W  burst length, 0..2*WIDTH+1
- X  out  1  extension bit
- A  out  WIDTH  register A
- B  out  WIDTH  register B
- A_out  out  1  A[0]
- B_out  out  1  B[0]
- Busy  out  1  burst in progress
- Done  out  1  one-cycle pulse at burst completion
- Shift_Count  out  CNT_W  shifts remaining in current burst

## Operation
- Reset low at an edge: X=0, A=0, B=0, counter=0, state IDLE, Busy=0, Done=0. Reset overrides every other input, including a burst in progress. No Done is produced for an aborted burst.
- Right shift: {X,A,B} <= {Xnew, X, A, B[WIDTH-1:1]}, where Xnew = Arith ? X : X_In.
- Left shift: {X,A,B} <= {A, B, X_In}. X takes A[WIDTH-1]. Arith is ignored.
- FSM states:
  - IDLE:
    - Priority is Burst_Start > Clear_XA/Ld_A/Ld_B > Shift_En.
    - Burst_Start with Burst_Len=L>0: counter<=L, go to SHIFT. No shift on this edge.
    - Burst_Start with L=0: go to DONE.
    - Clear_XA, Ld_A and Ld_B may act together. Clear_XA beats Ld_A for A.
    - Any clear/load in a cycle suppresses Shift_En entirely for that cycle.
    - Shift_En alone: one shift step using the current Dir/Arith/X_In.
  - SHIFT:
    - Busy=1. Each edge performs one shift and decrements the counter.
    - When the counter goes 1->0, go to DONE.
    - Ld_A, Ld_B, Clear_XA, Shift_En and Burst_Start are ignored.
    - Dir, Arith and X_In are sampled every edge and must be held stable by the user for the whole burst.
  - DONE: Done=1, Busy=0. Loads, shifts and Burst_Start are ignored. Unconditionally go to IDLE.
- Shift_Count = counter. It is 0 in IDLE and DONE.
- Burst_Len > 2*WIDTH+1 is outside the supported range. It executes literally (all bits shifted out) and must not hang the FSM.

## Timing
- Loads, clears and single shifts: results visible the cycle after the sampling edge.
- Burst of L>0:
  - Start sampled at edge t0.
  - Shifts occur at edges t1..tL.
  - Busy is high for cycles t0+..tL.
  - Done is high for exactly one cycle, following tL.
  - Start-to-Done latency is L+1 cycles.
- Burst of L=0: Done is high for the one cycle after t0. Busy never asserts. Registers are unchanged.
- A new Burst_Start is accepted in IDLE only, i.e. earliest in the cycle after Done.
- A_out and B_out are combinational from the A and B registers. All other outputs are registered or decoded from state.

## Test plan
- Single right shift, logical (WIDTH=8): X=0, A=0xA5, B=0x3C; Shift_En=1, Dir=0, Arith=0, X_In=1 -> X=1, A=0x52, B=0x9E, A_out=0, B_out=0.
- Arithmetic burst: from X=1, A=0x52, B=0x9E; Burst_Start, Burst_Len=8, Arith=1, Dir=0 -> Busy for 8 cycles, Shift_Count 8->1, then Done one cycle (9 cycles after start edge) with X=1, A=0xFF, B=0x52.
- Single left shift: X=0, A=0x80, B=0x01; Shift_En=1, Dir=1, X_In=0 -> X=1, A=0x00, B=0x02.
- Zero-length burst: Burst_Len=0 -> Done next cycle, Busy never high, X/A/B unchanged.
- Reset mid-burst: Burst_Len=8, drive Reset low after 3 shifts -> next cycle all outputs 0, state IDLE, no Done pulse.
- Conflicts:
  - While Busy, pulse Ld_A=1 with D_A=0x11, plus Shift_En and Burst_Start -> ignored; burst completes normally.
  - In IDLE, Ld_A=1 (D_A=0x33) together with Shift_En=1 -> A=0x33, X and B unchanged, no shift.
